// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the CompactRISC16 core.
// Decode and writeback reuse these types so that register indices, data
// words and the scoreboard bitmap are sized consistently everywhere.
package regfile_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int NUM_REGS   = 16;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;
  typedef logic [NUM_REGS-1:0]   busy_vec_t;

endpackage

// File: rtl/mux16_1.sv
// Single-bit 16:1 select used as one bit-slice of a register read port.
module mux16_1 (
  input  logic [15:0] d_i,
  input  logic [3:0]  sel_i,
  output logic        y_o
);

  // Pick the input bit addressed by the select lines.
  always_comb begin
    y_o = d_i[sel_i];
  end

endmodule

// File: rtl/regfile_read_port.sv
// One combinational read port: a column of mux16_1 bit-slices selects the
// addressed register, then same-cycle write data may override the result.
module regfile_read_port
  import regfile_pkg::*;
(
  input  reg_data_t [NUM_REGS-1:0] regs_i,
  input  reg_addr_t                raddr_i,
  input  logic                     fwd_en_i,
  input  reg_addr_t                waddr_i,
  input  reg_data_t                wdata_i,
  output reg_data_t                rdata_o
);

  reg_data_t muxData;

  // Bit-slice k gathers bit k of every register and selects by read address.
  for (genvar k = 0; k < DATA_WIDTH; k++) begin : gen_slice
    logic [NUM_REGS-1:0] column;

    for (genvar n = 0; n < NUM_REGS; n++) begin : gen_col
      assign column[n] = regs_i[n][k];
    end

    mux16_1 u_mux (
      .d_i   (column),
      .sel_i (raddr_i),
      .y_o   (muxData[k])
    );
  end

  // Forwarding sits after the muxes so the stored-value path stays untouched.
  always_comb begin
    rdata_o = muxData;
    if (fwd_en_i && (waddr_i == raddr_i)) begin
      rdata_o = wdata_i;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// 16x16 register file with one write port, two combinational read ports and
// a per-register pending-write scoreboard for read-after-write detection.
// The width parameters must match the regfile_pkg constants because the read
// ports are built from fixed 16:1 bit-slices.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 16,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  I_CLK,
  input  logic                  I_NRESET,
  input  logic                  I_WE,
  input  logic [ADDR_WIDTH-1:0] I_WADDR,
  input  logic [DATA_WIDTH-1:0] I_WDATA,
  input  logic                  I_RE_A,
  input  logic [ADDR_WIDTH-1:0] I_RADDR_A,
  input  logic                  I_RE_B,
  input  logic [ADDR_WIDTH-1:0] I_RADDR_B,
  input  logic                  I_ISSUE,
  input  logic [ADDR_WIDTH-1:0] I_ISSUE_ADDR,
  output logic [DATA_WIDTH-1:0] O_RDATA_A,
  output logic [DATA_WIDTH-1:0] O_RDATA_B,
  output logic [NUM_REGS-1:0]   O_BUSY,
  output logic                  O_HAZARD
);
  import regfile_pkg::*;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
  busy_vec_t                           busy_q;
  busy_vec_t                           busy_d;
  logic                                fwdEn;
  logic [DATA_WIDTH-1:0]               portDataA;
  logic [DATA_WIDTH-1:0]               portDataB;
  logic                                hitA;
  logic                                hitB;

  // Forwarding is disabled while reset is held so reads show the cleared file.
  assign fwdEn = BYPASS & I_WE & I_NRESET;

  // Register storage and scoreboard; reset clears both without waiting for a clock.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      if (I_WE) begin
        regs_q[I_WADDR] <= I_WDATA;
      end
      busy_q <= busy_d;
    end
  end

  // A completing write clears its bit, but a same-cycle issue to that register wins.
  always_comb begin
    busy_d = busy_q;
    if (I_WE) begin
      busy_d[I_WADDR] = 1'b0;
    end
    if (I_ISSUE) begin
      busy_d[I_ISSUE_ADDR] = 1'b1;
    end
  end

  regfile_read_port u_port_a (
    .regs_i   (regs_q),
    .raddr_i  (I_RADDR_A),
    .fwd_en_i (fwdEn),
    .waddr_i  (I_WADDR),
    .wdata_i  (I_WDATA),
    .rdata_o  (portDataA)
  );

  regfile_read_port u_port_b (
    .regs_i   (regs_q),
    .raddr_i  (I_RADDR_B),
    .fwd_en_i (fwdEn),
    .waddr_i  (I_WADDR),
    .wdata_i  (I_WDATA),
    .rdata_o  (portDataB)
  );

  // A read is hazardous when its register is pending and not being forwarded now.
  always_comb begin
    hitA      = I_RE_A & busy_q[I_RADDR_A] & ~(fwdEn & (I_WADDR == I_RADDR_A));
    hitB      = I_RE_B & busy_q[I_RADDR_B] & ~(fwdEn & (I_WADDR == I_RADDR_B));
    O_HAZARD  = hitA | hitB;
    O_BUSY    = busy_q;
    O_RDATA_A = I_NRESET ? portDataA : '0;
    O_RDATA_B = I_NRESET ? portDataB : '0;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one instance with forwarding and one
// without share the same stimulus so both behaviours can be compared.
module tb_regfile_scoreboard;

  logic        clk;
  logic        nreset;
  logic        we;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic        reA;
  logic [3:0]  raddrA;
  logic        reB;
  logic [3:0]  raddrB;
  logic        issue;
  logic [3:0]  issueAddr;

  logic [15:0] rdataA1, rdataB1, busy1;
  logic        hazard1;
  logic [15:0] rdataA0, rdataB0, busy0;
  logic        hazard0;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.BYPASS(1'b1)) dut (
    .I_CLK(clk), .I_NRESET(nreset), .I_WE(we), .I_WADDR(waddr), .I_WDATA(wdata),
    .I_RE_A(reA), .I_RADDR_A(raddrA), .I_RE_B(reB), .I_RADDR_B(raddrB),
    .I_ISSUE(issue), .I_ISSUE_ADDR(issueAddr),
    .O_RDATA_A(rdataA1), .O_RDATA_B(rdataB1), .O_BUSY(busy1), .O_HAZARD(hazard1)
  );

  regfile_scoreboard #(.BYPASS(1'b0)) dutNoFwd (
    .I_CLK(clk), .I_NRESET(nreset), .I_WE(we), .I_WADDR(waddr), .I_WDATA(wdata),
    .I_RE_A(reA), .I_RADDR_A(raddrA), .I_RE_B(reB), .I_RADDR_B(raddrB),
    .I_ISSUE(issue), .I_ISSUE_ADDR(issueAddr),
    .O_RDATA_A(rdataA0), .O_RDATA_B(rdataB0), .O_BUSY(busy0), .O_HAZARD(hazard0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [3:0] wa, input logic [15:0] wd,
                               input logic iss, input logic [3:0] ia);
    we = w; waddr = wa; wdata = wd; issue = iss; issueAddr = ia;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nreset = 1'b0;
    reA = 1'b0; raddrA = 4'd0; reB = 1'b0; raddrB = 4'd0;
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    #2;
    checkOutput("reset_rdata_a", rdataA1, 16'h0000);
    checkOutput("reset_busy", busy1, 16'h0000);
    checkOutput("reset_hazard", {15'd0, hazard1}, 16'h0000);
    tick();
    nreset = 1'b1;

    // write r3 then read it back
    applyStimulus(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    reA = 1'b1; raddrA = 4'd3;
    #1;
    checkOutput("read_r3", rdataA1, 16'hBEEF);
    checkOutput("read_r3_nofwd", rdataA0, 16'hBEEF);
    checkOutput("read_r3_busy", busy1, 16'h0000);
    checkOutput("read_r3_hazard", {15'd0, hazard1}, 16'h0000);

    // same-cycle forwarding on both ports
    reA = 1'b0;
    raddrA = 4'd7; raddrB = 4'd7;
    applyStimulus(1'b1, 4'd7, 16'h1234, 1'b0, 4'd0);
    #1;
    checkOutput("fwd_a", rdataA1, 16'h1234);
    checkOutput("fwd_b", rdataB1, 16'h1234);
    checkOutput("nofwd_a", rdataA0, 16'h0000);
    checkOutput("nofwd_b", rdataB0, 16'h0000);
    tick();
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    #1;
    checkOutput("nofwd_after_edge", rdataA0, 16'h1234);

    // issue r5, then read it while pending
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd5);
    tick();
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    reA = 1'b1; raddrA = 4'd5;
    #1;
    checkOutput("issue_r5_busy", busy1, 16'h0020);
    checkOutput("issue_r5_hazard", {15'd0, hazard1}, 16'h0001);
    checkOutput("issue_r5_hazard_nofwd", {15'd0, hazard0}, 16'h0001);
    applyStimulus(1'b1, 4'd5, 16'h00AA, 1'b0, 4'd0);
    #1;
    checkOutput("wb_r5_hazard", {15'd0, hazard1}, 16'h0000);
    checkOutput("wb_r5_hazard_nofwd", {15'd0, hazard0}, 16'h0001);
    checkOutput("wb_r5_fwd", rdataA1, 16'h00AA);
    tick();
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    #1;
    checkOutput("wb_r5_busy", busy1, 16'h0000);
    checkOutput("wb_r5_data", rdataA1, 16'h00AA);
    checkOutput("wb_r5_hazard_after", {15'd0, hazard1}, 16'h0000);

    // issue and write r9 in the same cycle: the new producer keeps it busy
    reA = 1'b0;
    applyStimulus(1'b1, 4'd9, 16'h5555, 1'b1, 4'd9);
    tick();
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    raddrA = 4'd9; reB = 1'b0; raddrB = 4'd9;
    #1;
    checkOutput("r9_data", rdataA1, 16'h5555);
    checkOutput("r9_busy", busy1, 16'h0200);
    checkOutput("r9_reb_off_hazard", {15'd0, hazard1}, 16'h0000);
    reB = 1'b1;
    #1;
    checkOutput("r9_reb_on_hazard", {15'd0, hazard1}, 16'h0001);
    reB = 1'b0;

    // fill every register, then sweep both ports in opposite directions
    for (int n = 0; n < 16; n++) begin
      applyStimulus(1'b1, 4'(n), 16'(16'h1111 * n), 1'b0, 4'd0);
      tick();
    end
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    for (int n = 0; n < 16; n++) begin
      raddrA = 4'(n);
      raddrB = 4'(15 - n);
      #1;
      checkOutput($sformatf("sweep_a_r%0d", n), rdataA1, 16'(16'h1111 * n));
      checkOutput($sformatf("sweep_b_r%0d", 15 - n), rdataB1, 16'(16'h1111 * (15 - n)));
    end
    checkOutput("sweep_busy", busy1, 16'h0000);

    // r2 = FFFF and busy, then reset between edges with a write pending
    applyStimulus(1'b1, 4'd2, 16'hFFFF, 1'b0, 4'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd2);
    tick();
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    reA = 1'b1; raddrA = 4'd2;
    #1;
    checkOutput("pre_reset_r2", rdataA1, 16'hFFFF);
    checkOutput("pre_reset_busy", busy1, 16'h0004);
    applyStimulus(1'b1, 4'd2, 16'h1234, 1'b1, 4'd2);
    nreset = 1'b0;
    #1;
    checkOutput("async_reset_r2", rdataA1, 16'h0000);
    checkOutput("async_reset_busy", busy1, 16'h0000);
    checkOutput("async_reset_hazard", {15'd0, hazard1}, 16'h0000);
    tick();
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    nreset = 1'b1;
    #1;
    checkOutput("reset_write_dropped", rdataA1, 16'h0000);
    checkOutput("reset_issue_dropped", busy1, 16'h0000);

    // first edge after reset release behaves normally
    applyStimulus(1'b1, 4'd2, 16'h00C3, 1'b0, 4'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    #1;
    checkOutput("post_reset_write", rdataA1, 16'h00C3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- 16-entry x 16-bit general-purpose register file for the CompactRISC16 core, with one synchronous write port and two combinational read ports.
- Includes a per-register pending-write scoreboard so that decode can detect read-after-write hazards.
- Sits directly upstream of the per-bit 16:1 read-select muxes: register contents feed each bit-slice mux, and the read address drives the mux select.
- Sits between decode (read and issue requests) and writeback (write requests).

Parameters:
- DATA_WIDTH, 16, register width in bits.
- ADDR_WIDTH, 4, register address width.
- NUM_REGS, 16, register count; must equal 2**ADDR_WIDTH.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = reads return the stored value only.

Ports:
- I_CLK  in  1  clock; all state updates on the rising edge.
- I_NRESET  in  1  reset; asynchronous, active-low.
- I_WE  in  1  write enable (writeback).
- I_WADDR  in  ADDR_WIDTH  write register index.
- I_WDATA  in  DATA_WIDTH  write data.
- I_RE_A  in  1  read port A is in use this cycle.
- I_RADDR_A  in  ADDR_WIDTH  read port A index.
- I_RE_B  in  1  read port B is in use this cycle.
- I_RADDR_B  in  ADDR_WIDTH  read port B index.
- I_ISSUE  in  1  an instruction issues that will later write I_ISSUE_ADDR.
- I_ISSUE_ADDR  in  ADDR_WIDTH  destination register of the issuing instruction.
- O_RDATA_A  out  DATA_WIDTH  read port A data.
- O_RDATA_B  out  DATA_WIDTH  read port B data.
- O_BUSY  out  NUM_REGS  scoreboard bitmap; bit n = write pending to register n.
- O_HAZARD  out  1  an enabled read targets a busy register that is not being forwarded.

Behaviour:
- Reset:
  - I_NRESET low immediately clears all registers to 16'h0000 and all O_BUSY bits to 0, independent of I_CLK.
  - While reset is held: O_RDATA_A/B = 0 (forwarding is suppressed), O_BUSY = 0, O_HAZARD = 0.
  - Reset asserted mid-operation discards any write or issue in that cycle.
  - The first edge after deassertion behaves normally.
- Write:
  - On a rising edge with I_WE=1, reg[I_WADDR] <= I_WDATA.
  - There is no reserved zero register; r0 is writable.
- Read:
  - Purely combinational, with zero-cycle latency from address change to data.
  - O_RDATA_x = reg[I_RADDR_x], regardless of I_RE_x.
- Bypass (BYPASS=1):
  - If I_WE=1 and I_WADDR == I_RADDR_x, O_RDATA_x = I_WDATA in the same cycle.
  - Both ports may forward simultaneously.
- Scoreboard, next-state per bit n on each rising edge:
  - Set if I_ISSUE=1 and I_ISSUE_ADDR == n.
  - Else cleared if I_WE=1 and I_WADDR == n.
  - Else held.
  - Issue and write to the same register in one cycle: the bit stays/becomes 1, because the new producer wins.
  - Issue to an already-busy register: the bit stays 1. This is a single-outstanding model, so decode must stall WAW.
  - A write to a non-busy register: the data is written and the busy bit stays 0.
- Hazard:
  - hit_x = I_RE_x & O_BUSY[I_RADDR_x] & ~(BYPASS & I_WE & (I_WADDR == I_RADDR_x)).
  - O_HAZARD = hit_A | hit_B. It is combinational and does not depend on I_ISSUE in the same cycle.
- Width and other rules:
  - Addresses are unsigned with full 0..15 decode; there is no out-of-range case.
  - Data is stored unmodified, with no sign or zero extension.

Decomposition:
- Shared package regfile_pkg holds:
  - The constants DATA_WIDTH=16, ADDR_WIDTH=4, NUM_REGS=16.
  - The types reg_addr_t, reg_data_t and busy_vec_t, reused by decode and writeback.
- One sub-module, regfile_read_port, is instantiated twice.
  - It builds the DATA_WIDTH-wide read from DATA_WIDTH instances of the existing mux16_1 bit-slice.
  - Bit-slice k is fed by bit k of all 16 registers and selected by the read address.
  - The bypass compare/select is applied after the mux.

Test Plan:
- Reset, then write r3=16'hBEEF, then next cycle read A=r3 -> O_RDATA_A=16'hBEEF, O_BUSY=16'h0000, O_HAZARD=0.
- BYPASS=1: same cycle I_WE=1, I_WADDR=7, I_WDATA=16'h1234, I_RADDR_A=I_RADDR_B=7 -> both outputs 16'h1234 before the edge. BYPASS=0: same stimulus -> both outputs show the old r7 value.
- Issue r5; next cycle read A r5 with I_RE_A=1 -> O_BUSY=16'h0020, O_HAZARD=1. Then I_WE r5=16'h00AA -> O_HAZARD=0 in that cycle, and O_BUSY=0 after the edge.
- Same cycle issue r9 and write r9=16'h5555 -> after the edge r9=16'h5555 and O_BUSY[9]=1. I_RE_B=0 with I_RADDR_B=9 -> O_HAZARD=0.
- Fill r0..r15 with value 16'h1111*n, then sweep both ports over all 16 addresses -> each read matches, and no cross-talk between registers.
- With r2 holding 16'hFFFF and r2 busy, pulse I_NRESET low between edges -> O_RDATA for r2 is 0 and O_BUSY=0 immediately. A write presented during reset is not stored.
